muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M/RV64M multiply-divide execution unit. It sits beside the single-cycle ALU in the execute stage and handles funct7=0000001 R-type ops.
- Operands are taken in with a valid/ready handshake. The unit runs a radix-2 shift-add or restoring-divide loop for XLEN cycles, then holds a tagged result until the consumer accepts it.
- Generalised over XLEN and tag width. Adds special-case fast paths and a flush input, which the ALU does not need.

Parameters:
- XLEN, 32, operand/result width (32 or 64)
- TAG_W, 5, width of destination tag carried alongside the op

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operands/op presented
- in_ready  output  1  unit can accept (high only in IDLE)
- op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a  input  XLEN  rs1 value
- b  input  XLEN  rs2 value
- tag_in  input  TAG_W  destination tag
- flush  input  1  abandon in-flight op
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- result  output  XLEN  op result
- tag_out  output  TAG_W  tag of result
- busy  output  1  high in any state except IDLE

Behaviour:
- Reset: state IDLE; out_valid=0, result=0, tag_out=0, busy=0, in_ready=1 from the first cycle after reset deasserts.
- Reset asserted mid-operation aborts the op with no output.
- States and transitions:
  - IDLE: in_ready=1. An accept (in_valid&in_ready&!flush, sampled at edge ending cycle T) registers op, tag, operand magnitudes and result sign. Normal ops go to CALC. Special cases go to DONE.
  - CALC: exactly XLEN cycles (T+1..T+XLEN), one bit per cycle, counter 0..XLEN-1.
    - Multiply: 2*XLEN-bit unsigned product of magnitudes.
    - Divide: unsigned restoring divide of magnitudes, producing quotient and remainder.
  - FIXUP (T+XLEN+1): apply sign and select the output.
    - Multiply sign: negate the 2*XLEN product if the result sign is set.
    - MUL takes the low XLEN bits; MULH/MULHSU/MULHU take the high XLEN bits.
    - DIV/REM signs: quotient negative iff a, b signs differ; remainder takes the sign of a.
  - DONE: out_valid=1 from T+XLEN+2, or from T+1 for special cases. result and tag_out are held stable until out_valid&out_ready, then IDLE next cycle.
- No accept in the same cycle as handoff: minimum issue interval is XLEN+3 cycles for normal ops, 2 for special cases.
- Signedness:
  - MUL/MULH/DIV/REM: a and b signed.
  - MULHSU: a signed, b unsigned.
  - MULHU/DIVU/REMU: both unsigned.
- Special cases, detected at accept:
  - Divide by zero: DIV/DIVU result all ones; REM/REMU result = a.
  - Signed overflow (DIV/REM with a=-2^(XLEN-1), b=-1): DIV result = a; REM result = 0.
- Magnitude of -2^(XLEN-1) must be handled as an unsigned XLEN-bit value without overflow.
- flush: in CALC, FIXUP or DONE, forces IDLE next cycle. out_valid drops next cycle and no result is delivered.
  - flush in IDLE with in_valid: nothing is accepted.
  - flush and out_ready together in DONE: flush wins, but the result is counted as not delivered only if out_ready was low.
- in_valid while not in IDLE is ignored; inputs need not be held.
- out_valid never deasserts without out_ready, flush or reset.

Decomposition:
- muldiv_pkg:
  - muldiv_op_t enum with the funct3 encodings above.
  - muldiv_state_t enum {IDLE, CALC, FIXUP, DONE}.
  - Localparam helper is_div(op)=op[2]; is_signed_a / is_signed_b functions of op.
- Single module, no sub-module. The datapath shares one XLEN+1-bit adder/subtractor between the multiply and divide iterations.

Test Plan:
1. MUL a=7, b=0xFFFFFFFD, accept at T -> result 0xFFFFFFEB, out_valid first high at T+34, tag echoed.
2. MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
3. DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC; REMU -> 0x00000001.
4. DIVU 5/0 -> 0xFFFFFFFF at T+1; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0, all at T+1.
5. out_ready low for 10 cycles in DONE -> result, tag_out, out_valid stable, in_ready=0. Raise out_ready -> IDLE next cycle; new op accepted the cycle after.
6. flush at T+5 during CALC -> IDLE at T+6, out_valid never asserted. reset at T+10 of a new op -> out_valid=0, result=0, in_ready=1 the next cycle.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and op-decoding helpers for the iterative multiply/divide unit.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package muldiv_pkg;

    // funct3 encodings of the RV32M/RV64M R-type ops (funct7 = 0000001)
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FIXUP = 2'd2,
        ST_DONE  = 2'd3
    } muldiv_state_t;

    // funct3[2] separates the divide group from the multiply group
    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    // rs1 is signed for MUL, MULH, MULHSU, DIV, REM
    function automatic logic is_signed_a(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

    // rs2 is signed for MUL, MULH, DIV, REM (MULHSU treats rs2 as unsigned)
    function automatic logic is_signed_b(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_MULH) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: radix-2 shift-add multiply and restoring divide on operand magnitudes.
// Latency: XLEN+2 cycles from accept to out_valid (1 cycle for divide-by-zero and signed overflow).
// Backpressure: in_ready only in IDLE; result/tag_out held in DONE until out_ready, flush or reset.
//
// Ports: clk/reset (sync, active-high); in_valid/in_ready/op/a/b/tag_in operand handshake;
//        flush abandons any in-flight op; out_valid/out_ready/result/tag_out result handshake;
//        busy is high whenever the unit is not IDLE.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] tag_out,
    output logic             busy
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_t    state;
    muldiv_op_t       op_q;
    logic             sign_a_q;
    logic             sign_b_q;
    logic [XLEN-1:0]  mag_b_q;
    logic [XLEN-1:0]  hi_q;     // product high half / partial remainder
    logic [XLEN-1:0]  lo_q;     // multiplier shifting out / dividend shifting out, quotient shifting in
    logic [CW-1:0]    cnt_q;
    logic [XLEN-1:0]  result_q;
    logic [TAG_W-1:0] tag_q;

    // ---------------- accept-time decode ----------------
    logic            accept;
    logic            sgn_a;
    logic            sgn_b;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] special_res;

    assign accept = in_valid && in_ready && !flush;
    assign sgn_a  = is_signed_a(op) && a[XLEN-1];
    assign sgn_b  = is_signed_b(op) && b[XLEN-1];
    // Negating MIN_INT yields MIN_INT again, which read as unsigned is exactly its magnitude.
    assign mag_a  = sgn_a ? -a : a;
    assign mag_b  = sgn_b ? -b : b;

    assign div_zero = is_div(op) && (b == '0);
    // Only the signed divide ops (funct3[0]==0) can overflow.
    assign div_ovf  = is_div(op) && !op[0] && (a == MIN_INT) && (b == {XLEN{1'b1}});

    always_comb begin
        special_res = '0;
        if (div_zero) begin
            special_res = op[1] ? a : {XLEN{1'b1}};
        end else begin
            special_res = op[1] ? '0 : a;
        end
    end

    // ---------------- shared XLEN+1-bit adder/subtractor ----------------
    // Multiply: hi + (lsb of multiplier ? mag_b : 0).
    // Divide:   {hi, next dividend bit} - mag_b, as x + ~y + 1; carry-out set means no borrow.
    logic            calc_mul;
    logic [XLEN:0]   add_x;
    logic [XLEN:0]   add_y;
    logic            add_cin;
    logic [XLEN:0]   add_sum;
    logic            add_co;

    assign calc_mul = !is_div(op_q);
    assign add_x    = calc_mul ? {1'b0, hi_q} : {hi_q, lo_q[XLEN-1]};
    assign add_y    = calc_mul ? (lo_q[0] ? {1'b0, mag_b_q} : '0) : ~{1'b0, mag_b_q};
    assign add_cin  = !calc_mul;
    assign {add_co, add_sum} = {1'b0, add_x} + {1'b0, add_y} + {{(XLEN+1){1'b0}}, add_cin};

    // ---------------- sign fix-up and output select ----------------
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s;
    logic [XLEN-1:0]   rem_s;
    logic [XLEN-1:0]   fix_res;

    assign prod   = {hi_q, lo_q};
    assign prod_s = (sign_a_q ^ sign_b_q) ? -prod : prod;
    assign quo_s  = (sign_a_q ^ sign_b_q) ? -lo_q : lo_q;
    assign rem_s  = sign_a_q ? -hi_q : hi_q;

    always_comb begin
        fix_res = '0;
        if (is_div(op_q)) begin
            fix_res = op_q[1] ? rem_s : quo_s;
        end else if (op_q == OP_MUL) begin
            fix_res = prod_s[XLEN-1:0];
        end else begin
            fix_res = prod_s[2*XLEN-1:XLEN];
        end
    end

    // ---------------- state and datapath registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            op_q     <= OP_MUL;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            mag_b_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            tag_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q     <= muldiv_op_t'(op);
                        tag_q    <= tag_in;
                        sign_a_q <= sgn_a;
                        sign_b_q <= sgn_b;
                        mag_b_q  <= mag_b;
                        hi_q     <= '0;
                        lo_q     <= mag_a;
                        cnt_q    <= '0;
                        if (div_zero || div_ovf) begin
                            result_q <= special_res;
                            state    <= ST_DONE;
                        end else begin
                            state    <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (flush) begin
                        state <= ST_IDLE;
                    end else begin
                        if (calc_mul) begin
                            // shift the running product right by one, sum bit 0 enters the low half
                            hi_q <= add_sum[XLEN:1];
                            lo_q <= {add_sum[0], lo_q[XLEN-1:1]};
                        end else begin
                            // restore (keep the shifted remainder) when the trial subtract borrowed
                            hi_q <= add_co ? add_sum[XLEN-1:0] : add_x[XLEN-1:0];
                            lo_q <= {lo_q[XLEN-2:0], add_co};
                        end
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            state <= ST_FIXUP;
                        end
                    end
                end
                ST_FIXUP: begin
                    if (flush) begin
                        state <= ST_IDLE;
                    end else begin
                        result_q <= fix_res;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (flush || out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign result    = result_q;
    assign tag_out   = tag_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit (XLEN=32): directed literal cases plus randomized traffic against a behavioural model.
// Latency: n/a.
// Backpressure: out_ready driven low for stretches and randomly during the random phase.
module tb_muldiv_unit;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
    localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       op = 3'd0;
    logic [XLEN-1:0]  a = '0;
    logic [XLEN-1:0]  b = '0;
    logic [TAG_W-1:0] tag_in = '0;
    logic             flush = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] tag_out;
    logic             busy;

    int n_chk  = 0;
    int n_fail = 0;

    // behavioural model state: 0 idle, 1 computing, 2 result offered
    int              m_ph    = 0;
    int              m_cnt   = 0;
    logic [31:0]     m_res   = '0;
    logic [4:0]      m_tag   = '0;
    logic            m_clean = 1'b0;
    logic            m_init  = 1'b0;
    int              n_deliv = 0;

    muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .tag_in    (tag_in),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .tag_out   (tag_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // RISC-V M-extension result computed with plain 64-bit arithmetic
    function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx;
        longint      sy;
        longint      uy;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        uy = longint'({32'b0, y});
        p  = '0;
        case (o)
            MUL:    begin p = sx * sy; return p[31:0]; end
            MULH:   begin p = sx * sy; return p[63:32]; end
            MULHSU: begin p = sx * uy; return p[63:32]; end
            MULHU:  begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
            DIV: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
                p = sx / sy;
                return p[31:0];
            end
            DIVU:   return (y == 0) ? 32'hFFFF_FFFF : x / y;
            REM: begin
                if (y == 0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
                p = sx % sy;
                return p[31:0];
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic logic is_special(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        return o[2] && ((y == 0) || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom % 8)
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return $urandom % 16;
            default: return $urandom;
        endcase
    endfunction

    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [4:0] t, input logic [31:0] exp, input int exp_lat, input int hold);
        int lat;
        check("model_pin", 64'(ref_result(o, x, y)), 64'(exp));
        check("in_ready_at_issue", 64'(in_ready), 64'd1);
        in_valid = 1'b1; op = o; a = x; b = y; tag_in = t;
        @(posedge clk); #1;
        in_valid = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom; tag_in = 5'($urandom);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(exp_lat));
        check("result", 64'(result), 64'(exp));
        check("tag_out", 64'(tag_out), 64'(t));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_out_valid", 64'(out_valid), 64'd1);
            check("hold_result", 64'(result), 64'(exp));
            check("hold_tag_out", 64'(tag_out), 64'(t));
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("idle_after_handoff", 64'(in_ready), 64'd1);
        check("valid_drop_after_handoff", 64'(out_valid), 64'd0);
    endtask

    initial begin
        int seen_valid;
        fork
            // behavioural model, advanced on every rising edge from the sampled inputs
            forever begin
                @(posedge clk);
                if (reset) begin
                    m_ph = 0; m_res = '0; m_tag = '0; m_clean = 1'b1; m_init = 1'b1;
                end else if (m_init) begin
                    case (m_ph)
                        0: if (in_valid && !flush) begin
                            m_res   = ref_result(op, a, b);
                            m_tag   = tag_in;
                            m_clean = 1'b0;
                            if (is_special(op, a, b)) m_ph = 2;
                            else begin m_ph = 1; m_cnt = XLEN + 1; end
                        end
                        1: if (flush) m_ph = 0;
                           else begin
                               m_cnt--;
                               if (m_cnt == 0) m_ph = 2;
                           end
                        default: if (flush || out_ready) begin
                            m_ph = 0;
                            if (out_ready) n_deliv++;
                        end
                    endcase
                end
            end
            // compare process, mid-cycle
            forever begin
                @(negedge clk);
                if (m_init) begin
                    check("cyc_out_valid", 64'(out_valid), 64'(m_ph == 2));
                    check("cyc_in_ready", 64'(in_ready), 64'(m_ph == 0));
                    check("cyc_busy", 64'(busy), 64'(m_ph != 0));
                    if (m_ph == 2 || m_clean) begin
                        check("cyc_result", 64'(result), 64'(m_res));
                        check("cyc_tag_out", 64'(tag_out), 64'(m_tag));
                    end
                end
            end
        join_none

        // reset state
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_tag_out", 64'(tag_out), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // multiply group
        do_op(MUL,    32'h0000_0007, 32'hFFFF_FFFD, 5'h11, 32'hFFFF_FFEB, 34, 0);
        do_op(MULH,   32'h8000_0000, 32'h8000_0000, 5'h02, 32'h4000_0000, 34, 0);
        do_op(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h03, 32'hFFFF_FFFE, 34, 0);
        do_op(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h04, 32'hFFFF_FFFF, 34, 0);
        // divide group
        do_op(DIV,    32'hFFFF_FFF9, 32'h0000_0002, 5'h05, 32'hFFFF_FFFD, 34, 0);
        do_op(REM,    32'hFFFF_FFF9, 32'h0000_0002, 5'h06, 32'hFFFF_FFFF, 34, 0);
        do_op(DIVU,   32'hFFFF_FFF9, 32'h0000_0002, 5'h07, 32'h7FFF_FFFC, 34, 0);
        do_op(REMU,   32'hFFFF_FFF9, 32'h0000_0002, 5'h08, 32'h0000_0001, 34, 0);
        // special cases, result one cycle after accept
        do_op(DIVU,   32'h0000_0005, 32'h0000_0000, 5'h09, 32'hFFFF_FFFF, 1, 0);
        do_op(REM,    32'h0000_0005, 32'h0000_0000, 5'h0A, 32'h0000_0005, 1, 0);
        do_op(DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'h0B, 32'h8000_0000, 1, 0);
        do_op(REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'h0C, 32'h0000_0000, 1, 0);
        // consumer stall for 10 cycles, then back-to-back issue
        do_op(MUL,    32'h0000_0003, 32'h0000_0005, 5'h1D, 32'h0000_000F, 34, 10);
        do_op(DIVU,   32'h0000_0064, 32'h0000_0007, 5'h1E, 32'h0000_000E, 34, 0);

        // flush in IDLE with in_valid: nothing accepted
        in_valid = 1'b1; flush = 1'b1; op = MUL; a = 32'd3; b = 32'd3;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check("idle_flush_in_ready", 64'(in_ready), 64'd1);
        check("idle_flush_busy", 64'(busy), 64'd0);

        // flush at T+5 during CALC
        in_valid = 1'b1; op = MULHU; a = 32'h1234_5678; b = 32'h9ABC_DEF0; tag_in = 5'h15;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_in_ready", 64'(in_ready), 64'd1);
        seen_valid = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen_valid++;
            @(posedge clk); #1;
        end
        check("flush_no_out_valid", 64'(seen_valid), 64'd0);

        // reset at T+10 of a new op
        in_valid = 1'b1; op = DIV; a = 32'h0000_1000; b = 32'h0000_0003; tag_in = 5'h16;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midop_rst_out_valid", 64'(out_valid), 64'd0);
        check("midop_rst_result", 64'(result), 64'd0);
        check("midop_rst_in_ready", 64'(in_ready), 64'd1);

        // randomized traffic checked every cycle by the compare process
        for (int cyc = 0; cyc < 8000; cyc++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom % 3) != 0;
            op        = 3'($urandom);
            a         = pick();
            b         = (($urandom % 6) == 0) ? 32'h0 : pick();
            tag_in    = 5'($urandom);
            flush     = ($urandom % 60) == 0;
            out_ready = ($urandom % 2) == 1;
            reset     = ($urandom % 1500) == 0;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0; reset = 1'b0; out_ready = 1'b1;
        repeat (40) begin @(posedge clk); #1; end
        check("drain_idle", 64'(in_ready), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
